// File: rtl/mac_pkg.sv
// Shared definitions for the shift-add MAC controller and its datapath.
package mac_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MUL  = 3'd2,
      S_ACC  = 3'd3,
      S_DONE = 3'd4
   } mac_state_e;

   localparam int unsigned MAC_WIDTH  = 8;
   localparam int unsigned MAC_TERM_W = 8;

endpackage

// File: rtl/mac_iter_cnt.sv
// Iteration counter: synchronous clear, enable, terminal count at WIDTH-1.
module mac_iter_cnt #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       en,
   output logic [$clog2(WIDTH)-1:0]   cnt,
   output logic                       tc
);

   localparam int unsigned CW = $clog2(WIDTH);

   always_comb begin
      tc = (cnt == CW'(WIDTH - 1));
   end

   // Returns to zero after the last iteration rather than relying on natural wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the shift-add multiply-accumulate datapath: LOAD, WIDTH x MUL,
// ACC, DONE, with abort back to IDLE.
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int unsigned WIDTH  = MAC_WIDTH,
   parameter int unsigned TERM_W = MAC_TERM_W
) (
   input  logic                       CLK,
   input  logic                       CLR,
   input  logic                       start,
   input  logic                       first,
   input  logic                       abort,
   input  logic                       q0,
   output logic                       ready,
   output logic                       ld_op,
   output logic                       add_en,
   output logic                       shift_en,
   output logic                       acc_add,
   output logic                       acc_load,
   output logic                       done,
   output logic                       busy,
   output logic [$clog2(WIDTH)-1:0]   bit_cnt,
   output logic [TERM_W-1:0]          term_cnt
);

   mac_state_e state;
   logic       first_q;
   logic       cnt_clr;
   logic       cnt_en;
   logic       cnt_tc;
   logic       in_flight;

   always_comb begin
      in_flight = (state == S_LOAD) || (state == S_MUL) || (state == S_ACC);
      cnt_clr   = (state == S_LOAD) || (abort && in_flight);
      cnt_en    = (state == S_MUL);
   end

   mac_iter_cnt #(
      .WIDTH (WIDTH)
   ) u_bit_cnt (
      .clk (CLK),
      .rst (CLR),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (bit_cnt),
      .tc  (cnt_tc)
   );

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state    <= S_IDLE;
         first_q  <= 1'b0;
         term_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  state   <= S_LOAD;
                  first_q <= first;
               end
            end
            S_LOAD: state <= abort ? S_IDLE : S_MUL;
            S_MUL: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (cnt_tc) begin
                  state <= S_ACC;
               end
            end
            S_ACC: begin
               if (abort) begin
                  state <= S_IDLE;
               end else begin
                  term_cnt <= first_q ? TERM_W'(1) : term_cnt + TERM_W'(1);
                  state    <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode the registered state; abort masks them in the same cycle.
   always_comb begin
      ready    = (state == S_IDLE);
      busy     = in_flight;
      ld_op    = (state == S_LOAD) && !abort;
      shift_en = (state == S_MUL) && !abort;
      add_en   = (state == S_MUL) && !abort && q0;
      acc_load = (state == S_ACC) && !abort && first_q;
      acc_add  = (state == S_ACC) && !abort && !first_q;
      done     = (state == S_DONE);
   end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- FSM controller that sequences the shift-add multiply-accumulate datapath built from the S-type mux/DFF logic cells.
- Accepts one MAC request per start/ready handshake and runs WIDTH add/shift iterations.
- Issues one accumulate or load strobe to the accumulator, then pulses done.
- Only control strobes and counters are produced here; operands and the product live in the datapath.

Parameters:
- WIDTH, 8, operand width = number of add/shift iterations per multiply (>=2).
- TERM_W, 8, width of the accumulated-term counter.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- CLR  input  1  asynchronous, active-high reset.
- start  input  1  request a MAC operation; accepted only when ready=1.
- first  input  1  sampled with an accepted start: 1 = product replaces the accumulator, 0 = product is added.
- abort  input  1  cancel an in-flight operation.
- q0  input  1  current multiplier LSB from the datapath shift register.
- ready  output  1  high only in IDLE.
- ld_op  output  1  load operand registers and clear the partial product.
- add_en  output  1  add multiplicand into the partial product this cycle.
- shift_en  output  1  shift the partial product/multiplier right one bit.
- acc_add  output  1  accumulator <= accumulator + product.
- acc_load  output  1  accumulator <= product.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high in LOAD, MUL and ACC.
- bit_cnt  output  $clog2(WIDTH)  current iteration index.
- term_cnt  output  TERM_W  number of terms in the accumulator since the last load.

Behaviour:
- Reset (CLR=1, asynchronous):
  - state=IDLE, bit_cnt=0, term_cnt=0, first flag=0.
  - All strobes and done=0; busy=0; ready=1.
- States: IDLE, LOAD, MUL, ACC, DONE. All strobes are decoded from registered state plus q0 (Moore except add_en).
- IDLE:
  - ready=1.
  - start=1 and abort=0 -> LOAD; first is captured into an internal flag.
  - start while not in IDLE is ignored (no queuing).
- LOAD (1 cycle): ld_op=1, bit_cnt<=0, -> MUL.
- MUL (exactly WIDTH cycles):
  - shift_en=1 every cycle; add_en=q0 (combinational, same cycle).
  - bit_cnt increments each cycle.
  - When bit_cnt==WIDTH-1 -> ACC and bit_cnt<=0 (no wrap into a WIDTH-th iteration).
- ACC (1 cycle):
  - Stored first=1: acc_load=1 and term_cnt<=1.
  - Otherwise: acc_add=1 and term_cnt<=term_cnt+1, wrapping modulo 2^TERM_W.
  - acc_add and acc_load are never both high.
  - -> DONE.
- DONE (1 cycle): done=1, -> IDLE.
- Latency, with start accepted at edge 0:
  - ld_op high in cycle 1.
  - MUL in cycles 2..WIDTH+1.
  - ACC in cycle WIDTH+2.
  - done in cycle WIDTH+3.
  - ready again in cycle WIDTH+4.
  - Back-to-back throughput: one MAC per WIDTH+4 cycles.
- abort:
  - In LOAD, MUL or ACC: no strobe is asserted that cycle (abort masks ld_op/add_en/shift_en/acc_*); next state IDLE; bit_cnt<=0; term_cnt unchanged; no done.
  - In IDLE or DONE: ignored. abort together with start in IDLE: start is not accepted.
- busy = state in {LOAD, MUL, ACC}. ready and busy are never both high.
- CLR asserted mid-operation: immediate return to reset values, with no partial strobes after deassertion.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum (IDLE=0, LOAD=1, MUL=2, ACC=3, DONE=4; 3-bit encoding);
  - the default WIDTH and TERM_W constants, reused by the datapath.
- One natural sub-module: mac_iter_cnt, a loadable up-counter with terminal-count flag (clear, enable, tc at WIDTH-1), instantiated for bit_cnt.
- FSM and term_cnt stay in the top.

Test Plan:
- Reset: hold CLR mid-MUL, then release -> ready=1, busy=0, all strobes 0, bit_cnt=0, term_cnt=0; no strobe on the first edge after release.
- Single op, WIDTH=8, first=1, q0 pattern 1,0,1,1,0,0,0,1:
  - ld_op in cycle 1;
  - shift_en in cycles 2-9, add_en high exactly in cycles 2,4,5,9;
  - acc_load in cycle 10, done in cycle 11;
  - term_cnt=1.
- Three ops: first=1 then first=0 twice -> acc_load once then acc_add twice; term_cnt=3; ready returns 12 cycles after each accepted start.
- start held high throughout an operation -> no second LOAD until IDLE; next op accepted exactly at the first ready=1 cycle.
- abort in the 4th MUL cycle -> no add_en/shift_en that cycle, IDLE next cycle, no acc strobe or done, term_cnt unchanged; abort+start in IDLE -> not accepted.
- TERM_W=2: five accumulating ops after a load -> term_cnt sequence 1,2,3,0,1,2 (wrap).
